gen_gamma_stream_coder: RTL and testbench

//  Streaming successor to the single-word gamma coder. Mixes a frame of input words with a per-word

---
 rtl/gen_gamma_stream_coder.sv | 136 +++++++++++++
 tb/tb_gen_gamma_stream_coder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_gamma_stream_coder.sv
// gen_gamma_stream_coder
// Streaming gamma coder: each word of a frame is mixed with a key taken from a
// seeded Galois LFSR. Encode adds the key (carry kept in the extra MSB), decode
// subtracts it and flags a borrow. Valid/ready handshakes on both sides, one
// word per cycle when downstream keeps up.
// Optional feature: define GEN_GAMMA_KEY_OUT_EN to add the out_key debug port,
// which shows the key used for the word currently on out_data.

module gen_gamma_stream_coder #(
    parameter int                DATA_W = 8,
    parameter int                LEN_W  = 8,
    parameter logic [DATA_W-1:0] POLY   = 8'hB8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_err,
    output logic              busy,
    output logic              done
`ifdef GEN_GAMMA_KEY_OUT_EN
    ,
    output logic [DATA_W-1:0] out_key
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] LFSR_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic               mode_q;
    logic [LEN_W-1:0]   frame_len_q;
    logic [LEN_W-1:0]   count;
    logic [DATA_W-1:0]  lfsr;

    logic               accept;
    logic               last_word;
    logic [DATA_W-1:0]  lfsr_next;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;

    // A new word may enter whenever the output register is empty or is being
    // drained this cycle, which gives full throughput under back-to-back traffic.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // frame_len of zero wraps to all-ones here, so a zero length means 2**LEN_W words.
    assign last_word = (count == (frame_len_q - CNT_ONE));

    // Galois LFSR step and the two mixing datapaths, computed from the current key.
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
    assign sum       = {1'b0, in_data[DATA_W-1:0]} + {1'b0, lfsr};
    assign diff      = in_data - {1'b0, lfsr};

    // Frame control FSM with registered output word, error flag and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: all state is assigned with <= so every register samples
            // pre-edge values; mixing in = here would create ordering races.
            state       <= IDLE;
            mode_q      <= 1'b0;
            frame_len_q <= '0;
            count       <= '0;
            lfsr        <= LFSR_ONE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            done        <= 1'b0;
`ifdef GEN_GAMMA_KEY_OUT_EN
            out_key     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort in IDLE suppresses a simultaneous start
                    if (start && !abort) begin
                        mode_q      <= mode;
                        frame_len_q <= frame_len;
                        lfsr        <= (seed == '0) ? LFSR_ONE : seed;
                        count       <= '0;
                        state       <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        count     <= '0;
                    end else begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                        // accept overrides the drain above: the slot is refilled
                        if (accept) begin
                            out_valid <= 1'b1;
                            out_data  <= mode_q ? {1'b0, diff[DATA_W-1:0]} : sum;
                            out_err   <= mode_q & diff[DATA_W];
`ifdef GEN_GAMMA_KEY_OUT_EN
                            out_key   <= lfsr;
`endif
                            lfsr      <= lfsr_next;
                            count     <= count + CNT_ONE;
                            if (last_word) begin
                                state <= DRAIN;
                            end
                        end
                        if ((state == DRAIN) && (!out_valid || out_ready)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_gamma_stream_coder.sv
// Directed bench for gen_gamma_stream_coder (default parameters: 8-bit data,
// 8-bit length, POLY 0xB8). Key sequence from seed 1: 01, B8, 5C, 2E, 17, B3...

module tb_gen_gamma_stream_coder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       mode;
    logic [7:0] seed;
    logic [7:0] frame_len;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic       out_err;
    logic       busy;
    logic       done;
`ifdef GEN_GAMMA_KEY_OUT_EN
    logic [7:0] out_key;
`endif

    int total;
    int bad;

    logic [8:0] vec_in  [256];
    logic [8:0] vec_out [256];
    logic       vec_err [256];
    logic [7:0] vec_key [256];

    gen_gamma_stream_coder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed      (seed),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy),
        .done      (done)
`ifdef GEN_GAMMA_KEY_OUT_EN
        ,
        .out_key   (out_key)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [8:0] din, input logic [8:0] dout,
                        input logic err, input logic [7:0] key);
        vec_in[i]  = din;
        vec_out[i] = dout;
        vec_err[i] = err;
        vec_key[i] = key;
    endtask

    // Reference Galois step: shift right, fold the tap mask back in when a 1 drops out.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] r;
        r = {1'b0, v[7:1]};
        if (v[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    // Start a frame and stream n words through it, comparing every output word.
    // stall_from/stall_len drop out_ready for a window; poke asserts start mid-frame.
    task automatic run_frame(input string name, input logic m, input logic [7:0] s,
                             input logic [7:0] len, input int n,
                             input int stall_from, input int stall_len, input bit poke);
        int         idx_in;
        int         idx_out;
        int         done_cnt;
        bit         prev_stalled;
        logic [8:0] prev_data;
        idx_in       = 0;
        idx_out      = 0;
        done_cnt     = 0;
        prev_stalled = 0;
        prev_data    = '0;
        mode      = m;
        seed      = s;
        frame_len = len;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy after start"}, busy, 1);
        for (int cyc = 0; cyc < n + 40; cyc++) begin
            if (idx_out == n && !busy) break;
            if (poke && cyc == 1) begin
                start     = 1'b1;
                mode      = ~m;
                seed      = 8'h55;
                frame_len = 8'd7;
            end else begin
                start = 1'b0;
            end
            in_valid  = (idx_in < n);
            in_data   = (idx_in < n) ? vec_in[idx_in] : 9'h000;
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (out_valid && out_ready) begin
                check({name, " data"}, out_data, vec_out[idx_out]);
                check({name, " err"}, out_err, vec_err[idx_out]);
`ifdef GEN_GAMMA_KEY_OUT_EN
                check({name, " key"}, out_key, vec_key[idx_out]);
`endif
                idx_out++;
            end
            if (out_valid && !out_ready) begin
                check({name, " in_ready in stall"}, in_ready, 0);
                if (prev_stalled) check({name, " held data"}, out_data, prev_data);
                prev_stalled = 1;
                prev_data    = out_data;
            end else begin
                prev_stalled = 0;
            end
            if (in_valid && in_ready) idx_in++;
            tick();
            if (done) done_cnt++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, " words out"}, idx_out, n);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " busy at end"}, busy, 0);
        tick();
        check({name, " done is a pulse"}, done, 0);
    endtask

    initial begin
        logic [7:0] k;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 1'b0;
        seed      = 8'h00;
        frame_len = 8'd0;
        in_valid  = 1'b0;
        in_data   = 9'h000;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset values
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 9'h000);
        check("rst out_err", out_err, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores in_valid; abort together with start keeps it idle
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        #1;
        check("idle in_ready", in_ready, 0);
        tick();
        check("idle no output", out_valid, 0);
        in_valid = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort idle", busy, 0);

        // 1: encode FF,10,00 with seed 1
        load(0, 9'h0FF, 9'h100, 0, 8'h01);
        load(1, 9'h010, 9'h0C8, 0, 8'hB8);
        load(2, 9'h000, 9'h05C, 0, 8'h5C);
        run_frame("enc3", 1'b0, 8'h01, 8'd3, 3, 100, 0, 0);

        // 2: decode back to the plaintext
        load(0, 9'h100, 9'h0FF, 0, 8'h01);
        load(1, 9'h0C8, 9'h010, 0, 8'hB8);
        load(2, 9'h05C, 9'h000, 0, 8'h5C);
        run_frame("dec3", 1'b1, 8'h01, 8'd3, 3, 100, 0, 0);

        // 3: decode borrow
        load(0, 9'h000, 9'h0FF, 1, 8'h01);
        run_frame("dec borrow", 1'b1, 8'h01, 8'd1, 1, 100, 0, 0);

        // 4: encode 4 words with out_ready low for 3 cycles mid-frame
        load(0, 9'h011, 9'h012, 0, 8'h01);
        load(1, 9'h022, 9'h0DA, 0, 8'hB8);
        load(2, 9'h033, 9'h08F, 0, 8'h5C);
        load(3, 9'h044, 9'h072, 0, 8'h2E);
        run_frame("enc stall", 1'b0, 8'h01, 8'd4, 4, 2, 3, 0);

        // 5: seed 0 behaves as seed 1; start while busy is ignored
        load(0, 9'h000, 9'h001, 0, 8'h01);
        load(1, 9'h000, 9'h0B8, 0, 8'hB8);
        run_frame("seed0 restart", 1'b0, 8'h00, 8'd2, 2, 100, 0, 1);

        // 6a: abort after two words of a five-word frame
        mode      = 1'b0;
        seed      = 8'h01;
        frame_len = 8'd5;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'h000;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre-abort out_valid", out_valid, 1);
        check("pre-abort data", out_data, 9'h0B8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort done", done, 0);
        tick();
        check("abort no late done", done, 0);

        // a fresh frame after abort starts its count from zero
        load(0, 9'h0FF, 9'h100, 0, 8'h01);
        load(1, 9'h010, 9'h0C8, 0, 8'hB8);
        run_frame("after abort", 1'b0, 8'h01, 8'd2, 2, 100, 0, 0);

        // 6b: reset in the middle of a frame
        mode      = 1'b0;
        seed      = 8'h01;
        frame_len = 8'd5;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        tick();
        in_valid = 1'b0;
        check("pre-reset out_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        check("mid rst out_valid", out_valid, 0);
        check("mid rst out_data", out_data, 9'h000);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("mid rst in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        // frame_len 0 means 256 words
        k = 8'h01;
        for (int i = 0; i < 256; i++) begin
            load(i, {1'b0, 8'(i)}, {1'b0, 8'(i)} + {1'b0, k}, 0, k);
            k = lfsr_step(k);
        end
        run_frame("len0", 1'b0, 8'h01, 8'd0, 256, 100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
